// File: rtl/local_bus_pkg.sv
// local_bus_pkg: shared widths, address map, store strobes and lane-enable helper
package local_bus_pkg;
  localparam int XLEN = 32;
  localparam int DMEM_AW = 14;
  localparam int GPI_W = 13;
  localparam int GPO_W = 8;
  localparam logic [XLEN-1:0] GPI_ADDR = 32'h8000_0000;
  localparam logic [XLEN-1:0] GPO_ADDR = 32'h8000_0004;
  localparam logic [2:0] WE_BYTE = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_WORD = 3'b100;
  typedef enum logic {RGN_RAM, RGN_IO} rgn_e;
  // Byte enables for a one-hot strobe; any other strobe pattern writes nothing.
  function automatic logic [3:0] lane_en(input logic [2:0] we, input logic [1:0] off);
    return we == WE_BYTE ? 4'b0001 << off :
           we == WE_HALF ? (off[1] ? 4'b1100 : 4'b0011) :
           we == WE_WORD ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/local_bus_if.sv
// local_bus_if: core data-port bus (address, store data/strobe, read data)
interface local_bus_if;
  import local_bus_pkg::*;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] qin;
  logic [XLEN-1:0] qout;
  logic [2:0] we;
  modport master(output addr, qin, we, input qout);
  modport slave(input addr, qin, we, output qout);
endinterface

// File: rtl/local_bus_dmem_ram.sv
// dmem_ram: single-port byte-lane data RAM, synchronous read-first
module dmem_ram
  import local_bus_pkg::*;
#(
  parameter int AW = DMEM_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-3:0]   idx,
  input  logic [3:0]      be,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata
);
  logic [XLEN-1:0] ram [2**(AW-2)];
  logic [XLEN-1:0] rdata_q;
  // byte-lane writes; contents are never reset
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (be[i]) ram[idx][i*8 +: 8] <= wdata[i*8 +: 8];
  // read register samples the pre-write word, giving read-first behaviour
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else rdata_q <= ram[idx];
  assign rdata = rdata_q;
endmodule

// File: rtl/local_bus.sv
// local_bus: data-side decoder routing core accesses to data RAM or GPIO registers
module local_bus
  import local_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  local_bus_if.slave       bus,
  input  logic [GPI_W-1:0] gpio_pin_in,
  output logic [GPO_W-1:0] gpio_pin_out
);
  logic            in_ram, is_gpi, is_gpo;
  logic [3:0]      be, ram_be;
  logic [XLEN-1:0] wdata, ram_rdata, io_d, io_q;
  logic [GPO_W-1:0] gpo_d, gpo_q;
  logic [GPI_W-1:0] sync1_d, sync1_q, sync2_d, sync2_q;
  rgn_e            rgn_d, rgn_q;
  // decode, lane placement and next state of the GPIO/read-path registers
  always_comb begin
    in_ram = bus.addr[XLEN-1:DMEM_AW] == '0;
    is_gpi = bus.addr[XLEN-1:2] == GPI_ADDR[XLEN-1:2];
    is_gpo = bus.addr[XLEN-1:2] == GPO_ADDR[XLEN-1:2];
    be = lane_en(bus.we, bus.addr[1:0]);
    ram_be = be & {4{in_ram & rst_n}};
    wdata = bus.we == WE_BYTE ? {4{bus.qin[7:0]}} :
            bus.we == WE_HALF ? {2{bus.qin[15:0]}} : bus.qin;
    gpo_d = is_gpo && be[0] ? bus.qin[GPO_W-1:0] : gpo_q;
    sync1_d = gpio_pin_in;
    sync2_d = sync1_q;
    rgn_d = in_ram ? RGN_RAM : RGN_IO;
    io_d = is_gpi ? XLEN'(sync2_q) : is_gpo ? XLEN'(gpo_q) : '0;
  end
  // GPO register, input synchronizer and registered region/IO read data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gpo_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      rgn_q <= RGN_RAM;
      io_q <= '0;
    end else begin
      gpo_q <= gpo_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      rgn_q <= rgn_d;
      io_q <= io_d;
    end
  assign bus.qout = rgn_q == RGN_RAM ? ram_rdata : io_q;
  assign gpio_pin_out = gpo_q;
  dmem_ram #(.AW(DMEM_AW)) u_ram (
    .clk(clk),
    .rst_n(rst_n),
    .idx(bus.addr[DMEM_AW-1:2]),
    .be(ram_be),
    .wdata(wdata),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_local_bus.sv
// tb_local_bus: directed + scoreboard bench for local_bus
module tb_local_bus;
  import local_bus_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [GPI_W-1:0] pin = '0;
  logic [GPO_W-1:0] pout;
  local_bus_if bus();
  local_bus dut (.clk(clk), .rst_n(rst_n), .bus(bus), .gpio_pin_in(pin), .gpio_pin_out(pout));
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic armed = 1'b0;
  logic [31:0] mem [int];
  logic [31:0] exp_q = '0;
  logic exp_known = 1'b1;
  logic [7:0] gpo_m = '0;
  logic [12:0] s1 = '0, s2 = '0;

  // reference model: memory as words, stores placed byte by byte
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q = '0; exp_known = 1'b1; gpo_m = '0; s1 = '0; s2 = '0;
    end else begin : mdl
      logic [31:0] a, d, w;
      int n, off;
      a = bus.addr; d = bus.qin;
      n = bus.we == 3'b001 ? 1 : bus.we == 3'b010 ? 2 : bus.we == 3'b100 ? 4 : 0;
      off = n == 1 ? int'(a[1:0]) : n == 2 ? int'(a[1]) * 2 : 0;
      if (a < 32'h4000) begin
        exp_known = mem.exists(int'(a >> 2));
        exp_q = exp_known ? mem[int'(a >> 2)] : '0;
      end else begin
        exp_known = 1'b1;
        exp_q = (a >> 2) == (32'h8000_0000 >> 2) ? {19'b0, s2} :
                (a >> 2) == (32'h8000_0004 >> 2) ? {24'b0, gpo_m} : '0;
      end
      if (a < 32'h4000 && n > 0) begin
        w = mem.exists(int'(a >> 2)) ? mem[int'(a >> 2)] : '0;
        for (int k = 0; k < n; k++) w[(off + k) * 8 +: 8] = d[k * 8 +: 8];
        mem[int'(a >> 2)] = w;
      end
      if ((a >> 2) == (32'h8000_0004 >> 2) && n > 0 && off == 0) gpo_m = d[7:0];
      s2 = s1; s1 = pin;
    end
  end

  always @(negedge clk) if (armed) begin
    total++;
    if ((exp_known && bus.qout !== exp_q) || pout !== gpo_m) begin
      bad++;
      $display("FAIL model t=%0t: qout=%h gpio=%h, expected qout=%h gpio=%h", $time, bus.qout, pout, exp_q, gpo_m);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
    bus.addr = a; bus.qin = d; bus.we = w;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.addr = '0; bus.qin = '0; bus.we = '0;
    #2 rst_n = 1'b0;
    #1 armed = 1'b1;
    chk("rst_qout", bus.qout, 32'h0);
    chk("rst_gpo", {24'b0, pout}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step(32'h10, 32'hDEADBEEF, 3'b100);
    step(32'h10, 32'h0, 3'b000);
    chk("word_rd", bus.qout, 32'hDEADBEEF);
    step(32'h0, 32'h0, 3'b100);
    step(32'h3, 32'hAA, 3'b001);
    step(32'h0, 32'h1234, 3'b010);
    step(32'h0, 32'h0, 3'b000);
    chk("byte_half", bus.qout, 32'hAA001234);
    step(32'h8000_0004, 32'h1A5, 3'b100);
    chk("gpo_pin", {24'b0, pout}, 32'hA5);
    step(32'h8000_0004, 32'h0, 3'b000);
    chk("gpo_rd", bus.qout, 32'hA5);
    pin = 13'h1ABC;
    repeat (3) step(32'h4000_0000, 32'h0, 3'b000);
    step(32'h8000_0000, 32'h0, 3'b000);
    chk("gpi_rd", bus.qout, 32'h1ABC);
    step(32'h4000_0000, 32'hFFFF_FFFF, 3'b100);
    step(32'h4000_0000, 32'h0, 3'b000);
    chk("unmapped_rd", bus.qout, 32'h0);
    chk("unmapped_gpo", {24'b0, pout}, 32'hA5);
    step(32'h4000, 32'h1234_5678, 3'b100);
    step(32'h0, 32'h0, 3'b000);
    chk("no_alias", bus.qout, 32'hAA001234);
    step(32'h4000, 32'h0, 3'b000);
    chk("ram_end_plus1", bus.qout, 32'h0);
    step(32'h3FFC, 32'h0BAD_CAFE, 3'b100);
    step(32'h3FFC, 32'h0, 3'b000);
    chk("ram_top", bus.qout, 32'h0BAD_CAFE);
    step(32'h10, 32'h1111_1111, 3'b011);
    step(32'h10, 32'h0, 3'b000);
    chk("multi_we", bus.qout, 32'hDEADBEEF);
    step(32'h10, 32'hCAFE_F00D, 3'b100);
    chk("rdw_old", bus.qout, 32'hDEADBEEF);
    step(32'h13, 32'h5566, 3'b010);
    chk("rdw_new", bus.qout, 32'hCAFE_F00D);
    step(32'h10, 32'h0, 3'b000);
    chk("half_hi", bus.qout, 32'h5566_F00D);
    step(32'h8000_0005, 32'h77, 3'b001);
    chk("gpo_lane1", {24'b0, pout}, 32'hA5);
    step(32'h8000_0004, 32'h3C, 3'b010);
    chk("gpo_half", {24'b0, pout}, 32'h3C);
    bus.addr = 32'h8000_0004; bus.qin = 32'hFF; bus.we = 3'b100;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_gpo", {24'b0, pout}, 32'h0);
    step(32'h10, 32'h9999_9999, 3'b100);
    rst_n = 1'b1;
    step(32'h10, 32'h0, 3'b000);
    chk("rst_mid_ram", bus.qout, 32'h5566_F00D);
    for (int i = 0; i < 4; i++) step(32'h20 + 32'(i * 4), $urandom, 3'b100);
    for (int i = 0; i < 60; i++) begin : rnd
      logic [31:0] a;
      logic [2:0] w;
      int r;
      r = $urandom_range(0, 9);
      a = r < 6 ? 32'h20 + 32'($urandom_range(0, 15)) :
          r < 8 ? 32'h8000_0004 + 32'($urandom_range(0, 3)) :
          r < 9 ? 32'h8000_0000 : 32'h4000_0000;
      r = $urandom_range(0, 5);
      w = r == 0 ? 3'b000 : r == 1 ? 3'b001 : r == 2 ? 3'b010 : r == 3 ? 3'b100 : r == 4 ? 3'b011 : 3'b110;
      if (i % 7 == 0) pin = 13'($urandom);
      step(a, $urandom, w);
    end
    step(32'h0, 32'h0, 3'b000);
    @(negedge clk);
    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
